pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
// PURPOSE
//  Parametrised, pipelined bidirectional barrel shifter; successor to the 8-bit combinational shifter.
//  Adds a WIDTH parameter, logical/arithmetic/rotate modes, one register per shift stage and
//  valid/ready handshakes on both sides. Sits between the ALU operand muxes and the writeback stage.
// PARAMETERS
//  WIDTH   8  data width; power of two, >= 2
//  TAG_W   4  width of the sideband tag carried unchanged alongside each operation
// PORTS
//  clk        in   1      single clock; all state changes on the rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      input operation present
//  in_ready   out  1      shifter can accept an input this cycle
//  in_data    in   WIDTH  operand
//  in_shamt   in   SHW    shift amount, SHW = $clog2(WIDTH)
//  in_dir     in   1      1 = left, 0 = right
//  in_mode    in   2      00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
//  in_tag     in   TAG_W  opaque tag, returned with the result
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts the result
//  out_data   out  WIDTH  shifted result
//  out_tag    out  TAG_W  tag of this result
//  out_carry  out  1      only when PBS_CARRY_OUT_EN is defined
// BEHAVIOUR
//  - Reset (rst_n=0, async): every stage valid=0; out_valid=0; out_data, out_tag and out_carry are 0.
//    in_ready returns to 1 on the first clock after rst_n rises.
//  - Stage k (k = 0..SHW-1) shifts by 2^k when shamt[k]=1, then registers the result.
//    Latency = SHW cycles from the input handshake to out_valid. Throughput is 1 op/cycle.
//  - Handshake: a transfer occurs when valid && ready. Per-stage ready_k = !valid_k || ready_{k+1};
//    the last stage's ready is out_ready, and in_ready = ready_0.
//    The pipeline holds up to SHW ops in flight. Bubbles collapse under back-pressure.
//    out_data/out_tag stay stable while out_valid && !out_ready.
//    in_ready may depend combinationally on out_ready.
//  - Arithmetic: logical fills with 0. Arithmetic right fills with in_data[WIDTH-1].
//    Arithmetic left behaves as logical left. Rotate wraps modulo WIDTH.
//  - shamt=0 passes data unchanged in every mode. Mode 11 behaves exactly as mode 00.
//  - Simultaneous input accept and output drain with a full pipeline: both transfers occur, no loss.
//  - Ordering: results leave strictly in acceptance order. Tags are never reordered.
//  - Reset asserted mid-operation: all in-flight ops are discarded; no partial result is emitted.
// CONFIGURATION
//  PBS_CARRY_OUT_EN defined:
//    - out_carry is the last bit shifted out, computed at stage 0 and piped with the data.
//    - Logical/arithmetic left: in_data[WIDTH-shamt]. Right: in_data[shamt-1].
//    - Rotate left: out_data[0]. Rotate right: out_data[WIDTH-1].
//    - shamt=0 gives 0.
//  PBS_CARRY_OUT_EN undefined: no out_carry port and no carry flops.
// STRUCTURE
//  - Package pbs_pkg holds the mode encodings (PBS_LOGICAL, PBS_ARITH, PBS_ROTATE) and the
//    stage payload struct {data, shamt, dir, mode, tag[, carry]}.
//  - One sub-module, pbs_stage, is instantiated SHW times with STAGE=k. It contains the conditional
//    2^k shift and the valid/ready pipeline register.
//  - The top module only chains the stages and drives the ports.
// TESTING (WIDTH=8, out_ready=1 unless stated)
//  1. 11110011, shamt=1, left, logical -> 11100110 after 3 cycles; carry=1.
//  2. 11110011, shamt=5, right: logical -> 00000111, arithmetic -> 11111111; carry=1 in both.
//  3. 10010111, shamt=5, left, rotate -> 11110010; right, rotate -> 10111100.
//     shamt=0, every mode -> 10010111.
//  4. out_ready=0, push tags 1..4 back-to-back:
//     - in_ready drops after 3 accepts and tag 4 stalls; outputs stay stable.
//     - Raise out_ready: tags 1,2,3,4 emerge on consecutive cycles.
//  5. Continuous valid input, out_ready toggling 1010...: no drop or duplicate; output count = input count.
//  6. rst_n=0 with 2 ops in flight -> out_valid=0 immediately, no stale result after release;
//     a new op issues normally.

Source files
------------

// File: rtl/pbs_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and direction values.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pbs_pkg;

    typedef enum logic [1:0] {
        PBS_LOGICAL = 2'b00,
        PBS_ARITH   = 2'b01,
        PBS_ROTATE  = 2'b10,
        PBS_RSVD    = 2'b11
    } pbs_mode_e;

    localparam logic PBS_DIR_RIGHT = 1'b0;
    localparam logic PBS_DIR_LEFT  = 1'b1;

endpackage

// File: rtl/pbs_stage.sv
// One shifter stage: conditionally shifts by 2^STAGE, then registers the payload (carry captured at stage 0 when PBS_CARRY_OUT_EN).
// Latency: 1 cycle.
// Backpressure: in_ready = !out_valid || out_ready, so a bubble in this stage is filled even while downstream stalls.
module pbs_stage
    import pbs_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  STAGE     = 0,
    parameter type payload_t = logic
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    output logic     in_ready,
    input  payload_t in_pl,
    output logic     out_valid,
    input  logic     out_ready,
    output payload_t out_pl
);

    localparam int SHW = $clog2(WIDTH);
    localparam int SH  = 1 << STAGE;

    payload_t         nxt;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] rol;
    logic [WIDTH-1:0] ror;
    logic             fill;
`ifdef PBS_CARRY_OUT_EN
    logic [SHW-1:0]   cidx;
`endif

    always_comb begin
        nxt  = in_pl;
        d    = in_pl.data;
        // Arithmetic right keeps the msb, which earlier stages already preserved.
        fill = (in_pl.mode == PBS_ARITH) && d[WIDTH-1];
        shl  = d << SH;
        shr  = (d >> SH) | ({WIDTH{fill}} << (WIDTH - SH));
        rol  = (d << SH) | (d >> (WIDTH - SH));
        ror  = (d >> SH) | (d << (WIDTH - SH));
        if (in_pl.shamt[STAGE]) begin
            if (in_pl.mode == PBS_ROTATE) begin
                nxt.data = (in_pl.dir == PBS_DIR_LEFT) ? rol : ror;
            end else begin
                nxt.data = (in_pl.dir == PBS_DIR_LEFT) ? shl : shr;
            end
        end
`ifdef PBS_CARRY_OUT_EN
        // Last bit out is in[W-shamt] going left, in[shamt-1] going right, for every mode.
        cidx = (in_pl.dir == PBS_DIR_LEFT) ? (~in_pl.shamt + 1'b1) : (in_pl.shamt - 1'b1);
        if (STAGE == 0) begin
            nxt.carry = (in_pl.shamt != '0) && d[cidx];
        end
`endif
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pl    <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_pl <= nxt;
            end
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined bidirectional barrel shifter (logical/arithmetic/rotate); PBS_CARRY_OUT_EN adds out_carry.
// Latency: $clog2(WIDTH) cycles, one register per binary shift stage; 1 op/cycle.
// Backpressure: valid/ready per stage, bubbles collapse; in_ready is combinational on out_ready.
module pipelined_barrel_shifter
    import pbs_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int TAG_W = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef PBS_CARRY_OUT_EN
    ,
    output logic             out_carry
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shamt;
        logic             dir;
        pbs_mode_e        mode;
        logic [TAG_W-1:0] tag;
`ifdef PBS_CARRY_OUT_EN
        logic             carry;
`endif
    } pbs_payload_t;

    pbs_payload_t pl  [SHW+1];
    logic         vld [SHW+1];
    logic         up;

    // Holds off input acceptance until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up <= 1'b0;
        end else begin
            up <= 1'b1;
        end
    end

    always_comb begin
        pl[0]       = '0;
        pl[0].data  = in_data;
        pl[0].shamt = in_shamt;
        pl[0].dir   = in_dir;
        pl[0].mode  = pbs_mode_e'(in_mode);
        pl[0].tag   = in_tag;
    end

    assign vld[0] = in_valid && up;

    for (genvar k = 0; k < SHW; k++) begin : g_stg
        logic up_rdy;
        logic dn_rdy;

        if (k == SHW - 1) begin : g_last
            assign dn_rdy = out_ready;
        end else begin : g_mid
            assign dn_rdy = g_stg[k+1].up_rdy;
        end

        pbs_stage #(
            .WIDTH     (WIDTH),
            .STAGE     (k),
            .payload_t (pbs_payload_t)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld[k]),
            .in_ready  (up_rdy),
            .in_pl     (pl[k]),
            .out_valid (vld[k+1]),
            .out_ready (dn_rdy),
            .out_pl    (pl[k+1])
        );
    end

    assign in_ready  = up && g_stg[0].up_rdy;
    assign out_valid = vld[SHW];
    assign out_data  = pl[SHW].data;
    assign out_tag   = pl[SHW].tag;
`ifdef PBS_CARRY_OUT_EN
    assign out_carry = pl[SHW].carry;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (WIDTH=8): shift table, stall/drain, toggled back-pressure, mid-flight reset.
module tb_pipelined_barrel_shifter;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_dir    = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_data   = '0;
    logic [2:0] in_shamt  = '0;
    logic [1:0] in_mode   = '0;
    logic [3:0] in_tag    = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [3:0] out_tag;
`ifdef PBS_CARRY_OUT_EN
    logic       out_carry;
`endif

    pipelined_barrel_shifter #(.WIDTH(8), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_dir    (in_dir),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef PBS_CARRY_OUT_EN
        ,
        .out_carry (out_carry)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_in  = 0;
    int n_out = 0;
    bit lat_on = 1'b0;
    bit stop5  = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic [3:0] t;
        logic       c;
        int         acc;
        bit         lat;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [7:0] d;
        logic [2:0] sh;
        logic       dir;
        logic [1:0] md;
        logic [7:0] ed;
        logic       ec;
    } vec_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output scoreboard, sampled 1 time unit before the next rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #9;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", out_data, e.d);
                check("out_tag", out_tag, e.t);
`ifdef PBS_CARRY_OUT_EN
                check("out_carry", out_carry, e.c);
`endif
                if (e.lat) check("latency", cyc - e.acc, 3);
            end
        end
    end

    // Called at a falling edge; returns at a falling edge after the op is accepted.
    task automatic send(input logic [7:0] d, input logic [2:0] sh, input logic dir,
                        input logic [1:0] md, input logic [3:0] t,
                        input logic [7:0] ed, input logic ec);
        exp_t e;
        bit   done = 1'b0;
        in_data  = d;
        in_shamt = sh;
        in_dir   = dir;
        in_mode  = md;
        in_tag   = t;
        in_valid = 1'b1;
        for (int w = 0; w < 40 && !done; w++) begin
            #4;
            if (in_ready) begin
                e = '{ed, t, ec, cyc, lat_on};
                sb.push_back(e);
                n_in++;
                done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("accept", done, 1);
    endtask

    task automatic drain();
        for (int w = 0; w < 60 && sb.size() != 0; w++) @(negedge clk);
        check("drain", sb.size(), 0);
    endtask

    vec_t vt[16] = '{
        '{8'hF3, 3'd1, 1'b1, 2'b00, 8'hE6, 1'b1},
        '{8'hF3, 3'd5, 1'b0, 2'b00, 8'h07, 1'b1},
        '{8'hF3, 3'd5, 1'b0, 2'b01, 8'hFF, 1'b1},
        '{8'h97, 3'd5, 1'b1, 2'b10, 8'hF2, 1'b0},
        '{8'h97, 3'd5, 1'b0, 2'b10, 8'hBC, 1'b1},
        '{8'h97, 3'd0, 1'b0, 2'b00, 8'h97, 1'b0},
        '{8'h97, 3'd0, 1'b0, 2'b01, 8'h97, 1'b0},
        '{8'h97, 3'd0, 1'b1, 2'b10, 8'h97, 1'b0},
        '{8'h97, 3'd0, 1'b1, 2'b11, 8'h97, 1'b0},
        '{8'hF3, 3'd1, 1'b1, 2'b01, 8'hE6, 1'b1},
        '{8'hF3, 3'd5, 1'b0, 2'b11, 8'h07, 1'b1},
        '{8'h73, 3'd2, 1'b0, 2'b01, 8'h1C, 1'b1},
        '{8'h97, 3'd4, 1'b1, 2'b10, 8'h79, 1'b1},
        '{8'h81, 3'd7, 1'b1, 2'b00, 8'h80, 1'b0},
        '{8'h80, 3'd7, 1'b0, 2'b01, 8'hFF, 1'b0},
        '{8'h80, 3'd7, 1'b0, 2'b00, 8'h01, 1'b0}
    };

    initial begin
        int in0;
        int out0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 0);
`ifdef PBS_CARRY_OUT_EN
        check("rst_out_carry", out_carry, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);

        // Directed shift table, one op at a time with latency check
        lat_on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(vt[i].d, vt[i].sh, vt[i].dir, vt[i].md, 4'(i), vt[i].ed, vt[i].ec);
            drain();
        end

        // Stall: three fill the pipe, the fourth waits; outputs hold
        lat_on    = 1'b0;
        out_ready = 1'b0;
        send(8'h11, 3'd0, 1'b0, 2'b00, 4'd1, 8'h11, 1'b0);
        send(8'h22, 3'd0, 1'b0, 2'b00, 4'd2, 8'h22, 1'b0);
        send(8'h33, 3'd0, 1'b0, 2'b00, 4'd3, 8'h33, 1'b0);
        in_data  = 8'h44;
        in_tag   = 4'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #4;
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_tag", out_tag, 1);
            check("stall_out_data", out_data, 8'h11);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #4;
            if (k == 1) begin
                check("release_in_ready", in_ready, 1);
                if (in_ready) begin
                    sb.push_back('{8'h44, 4'd4, 1'b0, cyc, 1'b0});
                    n_in++;
                end
            end
            check("burst_valid", out_valid, 1);
            check("burst_tag", out_tag, k);
            @(negedge clk);
            in_valid = 1'b0;
        end
        drain();

        // Continuous input against toggling out_ready
        in0  = n_in;
        out0 = n_out;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(8'(i * 7 + 3), 3'd0, 1'b0, 2'b00, 4'(i), 8'(i * 7 + 3), 1'b0);
                end
                stop5 = 1'b1;
            end
            begin
                for (int j = 0; j < 200; j++) begin
                    @(negedge clk);
                    if (stop5 && sb.size() == 0) break;
                    out_ready = ~out_ready;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("toggle_in_count", n_in - in0, 16);
        check("toggle_out_count", n_out - out0, 16);

        // Reset with two ops in flight
        out_ready = 1'b0;
        send(8'hA0, 3'd1, 1'b1, 2'b00, 4'd5, 8'h40, 1'b1);
        send(8'h5A, 3'd1, 1'b1, 2'b00, 4'd6, 8'hB4, 1'b0);
        @(negedge clk);
        #1;
        check("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_tag", out_tag, 0);
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_idle", out_valid, 0);
        end
        out0   = n_out;
        lat_on = 1'b1;
        send(8'h3C, 3'd2, 1'b1, 2'b00, 4'd7, 8'hF0, 1'b0);
        drain();
        check("post_rst_out_count", n_out - out0, 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
